// File: rtl/kmer_extender_seq.sv
// Sequential k-mer extender: holds a sequence window and turns a batch of
// k-mer indices into centred, edge-clamped fragments, one per handshake.
module kmer_extender_seq #(
  parameter int KMER_LEN      = 4,
  parameter int FRAG_LEN      = 8,
  parameter int BASE_LEN      = 4,
  parameter int MEM_BASES     = 32,
  parameter int MEM_LEN       = MEM_BASES * BASE_LEN,
  parameter int INDICES_COUNT = 2,
  parameter int INDICE_LEN    = $clog2(MEM_BASES),
  parameter int SLOT_LEN      = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                mem_valid,
  output logic                                mem_ready,
  input  logic [MEM_LEN-1:0]                  mem_data,
  input  logic                                idx_valid,
  output logic                                idx_ready,
  input  logic [INDICES_COUNT*INDICE_LEN-1:0] idx_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [FRAG_LEN*BASE_LEN-1:0]        out_frag,
  output logic [SLOT_LEN-1:0]                 out_slot,
  output logic                                out_clamped,
  output logic                                out_err,
  output logic                                out_last,
  output logic                                busy
);

  localparam int FLANK  = (FRAG_LEN - KMER_LEN) / 2;
  localparam int FRAG_W = FRAG_LEN * BASE_LEN;
  localparam int SW     = INDICE_LEN + 2;

  localparam logic signed [SW-1:0] FLANK_S = SW'(FLANK);
  localparam logic signed [SW-1:0] MAX_S   = SW'(MEM_BASES - FRAG_LEN);
  localparam logic [INDICE_LEN-1:0] MAX_START = INDICE_LEN'(MEM_BASES - FRAG_LEN);
  localparam logic [INDICE_LEN-1:0] ERR_LIM   = INDICE_LEN'(MEM_BASES - KMER_LEN);
  localparam logic [SLOT_LEN-1:0]   LAST_SLOT = SLOT_LEN'(INDICES_COUNT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic                                     mem_loaded;
  logic [MEM_LEN-1:0]                       win_q;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] idx_q;

  logic                   mem_hs, idx_hs, out_hs, at_last;
  logic [SLOT_LEN-1:0]    slot_nx;
  logic [INDICE_LEN-1:0]  cur_idx, start;
  logic signed [SW-1:0]   raw_s;
  logic                   lo_clip, hi_clip, idx_bad;
  logic [MEM_LEN-1:0]     shifted;
  logic [FRAG_W-1:0]      frag_d;
  logic                   clamp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    idx_ready = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_ready = 1'b1;
        idx_ready = mem_loaded & ~mem_valid;
        if (idx_valid & mem_loaded & ~mem_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (out_valid & out_ready & (out_slot == LAST_SLOT)) state_d = IDLE;
      end
    endcase
  end

  assign mem_hs  = mem_valid & mem_ready;
  assign idx_hs  = idx_valid & idx_ready;
  assign out_hs  = out_valid & out_ready;
  assign at_last = (out_slot == LAST_SLOT);
  assign slot_nx = out_slot + SLOT_LEN'(1);

  // The fragment is computed for whichever index loads next:
  // slot 0 of an incoming batch, or the following latched slot.
  always_comb begin
    cur_idx = idx_hs ? idx_data[INDICE_LEN-1:0] : idx_q[slot_nx];
    raw_s   = $signed({2'b00, cur_idx}) - FLANK_S;
    lo_clip = raw_s[SW-1];
    hi_clip = raw_s > MAX_S;
    idx_bad = cur_idx > ERR_LIM;
    if (lo_clip)      start = '0;
    else if (hi_clip) start = MAX_START;
    else              start = raw_s[INDICE_LEN-1:0];
    shifted = win_q << (32'(start) * BASE_LEN);
    frag_d  = idx_bad ? '0 : shifted[MEM_LEN-1 -: FRAG_W];
    clamp_d = ~idx_bad & (lo_clip | hi_clip);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_loaded  <= 1'b0;
      win_q       <= '0;
      idx_q       <= '0;
      out_valid   <= 1'b0;
      out_frag    <= '0;
      out_slot    <= '0;
      out_clamped <= 1'b0;
      out_err     <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (mem_hs) begin
        win_q      <= mem_data;
        mem_loaded <= 1'b1;
      end
      if (idx_hs) begin
        idx_q       <= idx_data;
        out_valid   <= 1'b1;
        out_slot    <= '0;
        out_frag    <= frag_d;
        out_clamped <= clamp_d;
        out_err     <= idx_bad;
        out_last    <= (LAST_SLOT == '0);
      end else if (out_hs) begin
        if (at_last) begin
          out_valid <= 1'b0;
        end else begin
          out_slot    <= slot_nx;
          out_frag    <= frag_d;
          out_clamped <= clamp_d;
          out_err     <= idx_bad;
          out_last    <= (slot_nx == LAST_SLOT);
        end
      end
    end
  end

endmodule

// File: tb/tb_kmer_extender_seq.sv
// Directed bench for kmer_extender_seq: window load, batches, clamping,
// out-of-range flag, backpressure, reload during RUN and async reset.
module tb_kmer_extender_seq;

  localparam logic [127:0] W1 = 128'h01234567899876543210001122334455;
  localparam logic [127:0] WF = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_valid;
  logic         mem_ready;
  logic [127:0] mem_data;
  logic         idx_valid;
  logic         idx_ready;
  logic [9:0]   idx_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_frag;
  logic [0:0]   out_slot;
  logic         out_clamped;
  logic         out_err;
  logic         out_last;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  logic [36:0] obs;
  logic [36:0] e;
  assign obs = {out_valid, out_frag, out_slot, out_clamped, out_err, out_last};

  kmer_extender_seq dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_frag(out_frag),
    .out_slot(out_slot), .out_clamped(out_clamped), .out_err(out_err),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] ev(input logic v, input logic [31:0] f,
                                     input logic s, input logic c,
                                     input logic er, input logic l);
    return {v, f, s, c, er, l};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_window(input logic [127:0] w);
    int n;
    mem_valid = 1'b1;
    mem_data  = w;
    #1;
    n = 0;
    while (!mem_ready && n < 20) begin
      tick;
      n++;
    end
    vectors++;
    if (mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_timeout mem_ready=%b want 1", mem_ready);
    end
    tick;
    mem_valid = 1'b0;
  endtask

  task automatic send_batch(input logic [4:0] s0, input logic [4:0] s1);
    int n;
    idx_data  = {s1, s0};
    idx_valid = 1'b1;
    #1;
    n = 0;
    while (!idx_ready && n < 20) begin
      tick;
      n++;
    end
    vectors++;
    if (idx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL batch_timeout idx_ready=%b want 1", idx_ready);
    end
    tick;
    idx_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    e = '0;
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset_out got %h want %h", obs, e);
    end
    vectors++;
    if ({mem_ready, idx_ready, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 100", {mem_ready, idx_ready, busy});
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_no_window;
    idx_data  = {5'd15, 5'd1};
    idx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if ({idx_ready, out_valid, mem_ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL no_window c%0d got %b want 001", i,
                 {idx_ready, out_valid, mem_ready});
      end
    end
    idx_valid = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_batch(5'd1, 5'd15);
    e = ev(1, 32'h01234567, 0, 1, 0, 0);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL basic_s0 got %h want %h", obs, e);
    end
    tick;
    e = ev(1, 32'h65432100, 1, 0, 0, 1);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL basic_s1 got %h want %h", obs, e);
    end
    tick;
    vectors++;
    if ({out_valid, idx_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL basic_done got %b want 010", {out_valid, idx_ready, busy});
    end
  endtask

  task automatic test_edges;
    out_ready = 1'b1;
    send_batch(5'd28, 5'd29);
    e = ev(1, 32'h22334455, 0, 1, 0, 0);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL edge_hi got %h want %h", obs, e);
    end
    tick;
    e = ev(1, 32'h0, 1, 0, 1, 1);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL edge_err got %h want %h", obs, e);
    end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_batch(5'd10, 5'd1);
    e = ev(1, 32'h89987654, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL bp_hold c%0d got %h want %h", i, obs, e);
      end
      if (i < 2) tick;
    end
    out_ready = 1'b1;
    tick;
    e = ev(1, 32'h01234567, 1, 1, 0, 1);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL bp_adv got %h want %h", obs, e);
    end
    tick;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_end out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reload;
    out_ready = 1'b0;
    send_batch(5'd1, 5'd15);
    mem_valid = 1'b1;
    mem_data  = WF;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({mem_ready, busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL reload_run c%0d got %b want 01", i, {mem_ready, busy});
      end
      tick;
    end
    out_ready = 1'b1;
    tick;
    vectors++;
    if ({mem_ready, out_valid, out_slot} !== 3'b011) begin
      miscompares++;
      $display("FAIL reload_s1 got %b want 011", {mem_ready, out_valid, out_slot});
    end
    tick;
    vectors++;
    if ({mem_ready, idx_ready, out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reload_idle got %b want 100",
               {mem_ready, idx_ready, out_valid});
    end
    tick;
    mem_valid = 1'b0;
    send_batch(5'd1, 5'd15);
    e = ev(1, 32'hFFFFFFFF, 0, 1, 0, 0);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reload_f0 got %h want %h", obs, e);
    end
    tick;
    e = ev(1, 32'hFFFFFFFF, 1, 0, 0, 1);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reload_f1 got %h want %h", obs, e);
    end
    tick;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send_batch(5'd1, 5'd15);
    out_ready = 1'b1;
    tick;
    vectors++;
    if ({out_valid, out_slot, busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL ar_pre got %b want 111", {out_valid, out_slot, busy});
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({obs, busy, idx_ready, mem_ready} !== {37'd0, 3'b001}) begin
      miscompares++;
      $display("FAIL ar_clear got %h/%b want 0/001", obs,
               {busy, idx_ready, mem_ready});
    end
    #2 rst = 1'b0;
    idx_data  = {5'd15, 5'd1};
    idx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if ({idx_ready, out_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL ar_noload c%0d got %b want 00", i, {idx_ready, out_valid});
      end
    end
    idx_valid = 1'b0;
    load_window(W1);
    send_batch(5'd1, 5'd15);
    e = ev(1, 32'h01234567, 0, 1, 0, 0);
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL ar_recover got %h want %h", obs, e);
    end
    tick;
    tick;
  endtask

  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_data  = '0;
    idx_valid = 1'b0;
    idx_data  = '0;
    out_ready = 1'b0;
    test_reset;
    test_no_window;
    load_window(W1);
    test_basic;
    test_edges;
    test_backpressure;
    test_reload;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kmer_extender_seq.md
# kmer_extender_seq

Sequential, handshaked successor to the combinational k-mer extender. It holds a loaded sequence window in a register. It accepts a batch of k-mer start indices from the hasher and emits one extended fragment per index, at up to one per cycle. Each fragment is centred on its k-mer and clamped to the window edges. Out-of-range indices are flagged. It sits between the hasher (index source) and the downstream fragment consumer.

## Interface
- KMER_LEN, 4: k-mer length in bases
- FRAG_LEN, 8: extended fragment length in bases; FRAG_LEN >= KMER_LEN, (FRAG_LEN-KMER_LEN) even, FRAG_LEN <= MEM_BASES
- BASE_LEN, 4: bits per base
- MEM_BASES, 32: window length in bases
- MEM_LEN, MEM_BASES*BASE_LEN: window width in bits
- INDICES_COUNT, 2: indices per batch (>= 1)
- INDICE_LEN, $clog2(MEM_BASES): index width
- SLOT_LEN, max(1,$clog2(INDICES_COUNT)): slot number width
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  window load request
- mem_ready  out  1  window load accepted
- mem_data  in  MEM_LEN  window; base i = bits [MEM_LEN-1-i*BASE_LEN -: BASE_LEN] (base 0 in MSBs)
- idx_valid  in  1  batch offered
- idx_ready  out  1  batch accepted
- idx_data  in  INDICES_COUNT*INDICE_LEN  packed indices [INDICES_COUNT-1:0][INDICE_LEN-1:0]
- out_valid  out  1  fragment valid
- out_ready  in  1  consumer accepts
- out_frag  out  FRAG_LEN*BASE_LEN  fragment; fragment base 0 in MSBs
- out_slot  out  SLOT_LEN  batch position of this result
- out_clamped  out  1  start was clamped to a window edge
- out_err  out  1  index > MEM_BASES-KMER_LEN; out_frag forced to 0
- out_last  out  1  final result of the batch
- busy  out  1  state RUN

## Operation
- FLANK = (FRAG_LEN-KMER_LEN)/2. Raw start s = idx - FLANK, computed signed with INDICE_LEN+2 bits.
- Start = 0 if s < 0. Start = MEM_BASES-FRAG_LEN if s > MEM_BASES-FRAG_LEN. Otherwise start = s. out_clamped = 1 in either clamped case.
- out_err has priority over clamping. When it is set, out_frag = 0 and out_clamped = 0.
- Fragment = window bases start..start+FRAG_LEN-1.
- States:
  - IDLE: mem_ready = 1. idx_ready = mem_loaded & !mem_valid.
  - A mem handshake writes the window register and sets mem_loaded.
  - A batch handshake latches all indices, computes slot 0 into the output registers, sets out_valid, and moves to RUN.
  - RUN: mem_ready = 0, idx_ready = 0.
  - On out_valid & out_ready with slot < INDICES_COUNT-1: the output registers load slot+1 on the same edge, and out_valid stays high.
  - On handshake of the last slot: out_valid falls, and the state returns to IDLE.
- A load and a batch can never be accepted in the same cycle, because idx_ready is gated by mem_valid.
- A window load in IDLE does not disturb an already-idle output.
- Outputs hold stable while out_valid & !out_ready.

## Timing
- Reset values: every output 0, except mem_ready = 1. State IDLE, mem_loaded = 0, window register 0, slot counter 0.
- Reset asserted mid-RUN clears all outputs immediately (asynchronously). The pending batch is discarded, and a window reload is required.
- Batch accepted at edge N → out_valid at N+1.
- Throughput: 1 result per cycle with out_ready held high. A batch of C indices occupies C cycles of out_valid. idx_ready rises the cycle after the last handshake.
- mem_ready → new window is visible to the next batch accepted at least one cycle later.
- INDICES_COUNT = 1: out_last is always 1, and RUN lasts until the single handshake.

## Test plan
- Reset, then idx_valid = 1 with no window loaded → idx_ready stays 0 and out_valid stays 0; mem_ready = 1.
- Load window 128'h01234567899876543210001122334455, batch {15, 1} (slot0 = 1, slot1 = 15), out_ready = 1 → two consecutive out_valid cycles starting one cycle after acceptance:
  - slot0: out_frag 32'h01234567, out_clamped = 1, out_last = 0
  - slot1: out_frag 32'h65432100, out_clamped = 0, out_last = 1
- Same window, batch slot0 = 28, slot1 = 29:
  - slot0: out_frag 32'h22334455, out_clamped = 1
  - slot1: out_frag 0, out_err = 1, out_clamped = 0
- Backpressure: batch slot0 = 10, slot1 = 1, with out_ready low for 3 cycles → out_frag holds 32'h89987654 with out_slot 0 for all 3 cycles. It then advances to 32'h01234567 on the cycle after out_ready rises; no result is dropped or duplicated.
- Window reload: mem_valid asserted during RUN → mem_ready = 0 until the batch completes. Once back in IDLE, load 128'hFFFF…F, then batch {15, 1} → out_frag 32'hFFFFFFFF for both slots.
- Async reset asserted between two handshakes of a batch → out_valid, busy and idx_ready drop immediately. After release, idx_ready = 0 until a new window is loaded.
